rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, 12, tile-ROM address width.
REQ-002 Parameter DATA_W, 24, tile-ROM data width (RGB888).
REQ-003 Parameter STARVE_LIMIT, 1023, consecutive un-granted request cycles before the starvation flag sets; width 16 bits.
REQ-004 clk  input  1  single system clock; the ROM and VGA pipeline are on this clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 vga_active  input  1  VGA pixel pipeline needs the ROM port this cycle (active display area).
REQ-007 vga_addr  input  ADDR_W  VGA pixel fetch address.
REQ-008 vga_data  output  DATA_W  ROM data returned to the VGA pipeline.
REQ-009 aux_req  input  1  auxiliary requester (score/animation renderer) wants one ROM read.
REQ-010 aux_addr  input  ADDR_W  auxiliary read address; held stable while aux_req=1 and aux_gnt=0.
REQ-011 aux_gnt  output  1  one-cycle grant; aux_addr is on the ROM port this cycle.
REQ-012 aux_valid  output  1  one-cycle pulse; aux_data holds the granted read result.
REQ-013 aux_data  output  DATA_W  registered auxiliary read data.
REQ-014 rom_addr  output  ADDR_W  address to the single-port ROM (addra).
REQ-015 rom_dout  input  DATA_W  ROM output (douta), valid 1 cycle after address sampled.
REQ-016 starve_clr  input  1  clears aux_starved.
REQ-017 aux_starved  output  1  sticky starvation flag.

Function
REQ-018 VGA has absolute priority: whenever vga_active=1, rom_addr shall equal vga_addr combinationally and aux_gnt shall be 0.
REQ-019 vga_data shall equal rom_dout combinationally; VGA fetch latency stays exactly 1 cycle, unchanged by the arbiter.
REQ-020 States: IDLE, RD; encoded in a registered state variable.
REQ-021 IDLE: aux_gnt = aux_req & ~vga_active (combinational); rom_addr = aux_addr when aux_gnt=1, else vga_addr; on aux_gnt go to RD, else stay IDLE.
REQ-022 RD (cycle N+1 after grant in N): rom_addr = vga_addr, aux_gnt=0 regardless of aux_req; rom_dout captured into aux_data at cycle end; next state IDLE.
REQ-023 aux_valid shall be 1 in cycle N+2 only (registered from RD); aux_data stable until the next capture.
REQ-024 Requester shall drop aux_req in the cycle after aux_gnt; a still-high aux_req in IDLE at N+2 is a new request (max grant rate one per 2 cycles).
REQ-025 vga_active rising during RD causes no conflict; the aux read completes and aux_valid still pulses in N+2.
REQ-026 aux_req with vga_active=1 continuously: no grant, no valid; request remains pending until vga_active=0.
REQ-027 rom_addr, vga_data, aux_gnt have no register stage; aux_valid, aux_data, state are registered.

Reset
REQ-028 rst=1 asynchronously forces state=IDLE, aux_valid=0, aux_data=0, aux_starved=0, starvation counter=0.
REQ-029 rst during RD aborts the read; no aux_valid pulse follows; requester re-requests.
REQ-030 During reset rom_addr = vga_addr, aux_gnt=0.

Configuration
REQ-031 Macro ROM_ARB_WATCHDOG_EN defined: 16-bit counter increments each cycle aux_req=1 & aux_gnt=0, saturates at STARVE_LIMIT, clears on aux_gnt=1 or aux_req=0.
REQ-032 With ROM_ARB_WATCHDOG_EN: aux_starved sets the cycle after counter reaches STARVE_LIMIT, stays 1 until starve_clr=1 or rst; set wins over simultaneous starve_clr.
REQ-033 Without ROM_ARB_WATCHDOG_EN: no counter, aux_starved tied 0, starve_clr ignored; ports unchanged.

Verification
REQ-034 vga_active=1, vga_addr=0x123, ROM model returns 0xA5A5A5 for 0x123 -> rom_addr=0x123 same cycle, vga_data=0xA5A5A5 next cycle; aux_gnt=0.
REQ-035 vga_active=0, aux_req=1, aux_addr=0x7FF, ROM[0x7FF]=0x00FF00 -> aux_gnt in N, rom_addr=0x7FF in N, aux_valid=1 and aux_data=0x00FF00 in N+2.
REQ-036 aux_req=1 while vga_active=1 for 50 cycles then 0 -> no grant for 50 cycles, aux_gnt on first cycle vga_active=0.
REQ-037 Grant in N, vga_active=1 in N+1 with vga_addr=0x010 -> rom_addr=0x010 in N+1, aux_valid still pulses in N+2 with correct aux data.
REQ-038 rst pulse in RD cycle -> no aux_valid, aux_data=0, state IDLE.
REQ-039 ROM_ARB_WATCHDOG_EN, STARVE_LIMIT=8, aux_req=1, vga_active=1 for 20 cycles -> aux_starved=1 from cycle 9; starve_clr pulse -> 0 after counter clears; macro undefined -> aux_starved always 0.

Source files
------------

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - single-port tile-ROM arbiter, VGA priority over one auxiliary reader
//
// Purpose:
//   Shares one synchronous single-port ROM between the VGA pixel pipeline and
//   an auxiliary requester. VGA always wins and keeps its 1-cycle fetch
//   latency. The auxiliary reader gets a one-cycle grant when VGA is idle,
//   and its data comes back registered two cycles after the grant.
//
// Optional feature:
//   ROM_ARB_WATCHDOG_EN - when defined, a 16-bit starvation counter drives the
//   sticky aux_starved flag. When undefined, aux_starved is tied low and
//   starve_clr is ignored.
//
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   vga_active   - VGA pipeline owns the ROM port this cycle
//   vga_addr     - VGA fetch address
//   vga_data     - ROM data to VGA (combinational from rom_dout)
//   aux_req      - auxiliary read request
//   aux_addr     - auxiliary read address
//   aux_gnt      - one-cycle grant, aux_addr is on rom_addr this cycle
//   aux_valid    - one-cycle pulse, aux_data holds the granted read
//   aux_data     - registered auxiliary read data
//   rom_addr     - ROM address (addra)
//   rom_dout     - ROM data (douta), one cycle after address
//   starve_clr   - clears aux_starved
//   aux_starved  - sticky starvation flag

module rom_arbiter #(
  parameter int          ADDR_W       = 12,
  parameter int          DATA_W       = 24,
  parameter logic [15:0] STARVE_LIMIT = 16'd1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_active,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_valid,
  output logic [DATA_W-1:0] aux_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  input  logic              starve_clr,
  output logic              aux_starved
);

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_t;

  state_t state;

  // Grant only from IDLE, so back-to-back grants are at least two cycles
  // apart and the RD cycle always hands the port back to VGA. Gating with
  // rst keeps the port on VGA while reset is held.
  assign aux_gnt  = (state == IDLE) & aux_req & ~vga_active & ~rst;
  assign rom_addr = aux_gnt ? aux_addr : vga_addr;

  // VGA sees the ROM directly, so its latency is the ROM's own one cycle.
  assign vga_data = rom_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      aux_valid <= 1'b0;
      aux_data  <= '0;
    end else begin
      aux_valid <= (state == RD);
      case (state)
        IDLE: begin
          if (aux_gnt) begin
            state <= RD;
          end
        end
        RD: begin
          // rom_dout now carries the word addressed during the grant cycle.
          aux_data <= rom_dout;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_ARB_WATCHDOG_EN
  logic [15:0] starve_cnt;
  logic [15:0] starve_cnt_nxt;
  logic        starve_set;

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!aux_req || aux_gnt) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt < STARVE_LIMIT) begin
      starve_cnt_nxt = starve_cnt + 16'd1;
    end
  end

  // The flag is raised on the same edge that loads the limit into the
  // counter, so it is visible in the cycle after the count reaches the limit.
  assign starve_set = aux_req & ~aux_gnt & (starve_cnt_nxt == STARVE_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      aux_starved <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      if (starve_set) begin
        aux_starved <= 1'b1;
      end else if (starve_clr) begin
        aux_starved <= 1'b0;
      end
    end
  end
`else
  logic unused_starve_clr;
  assign unused_starve_clr = starve_clr;
  assign aux_starved       = 1'b0;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter

module tb_rom_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;
`ifdef ROM_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vga_active = 1'b0;
  logic [ADDR_W-1:0] vga_addr = 12'h055;
  logic [DATA_W-1:0] vga_data;
  logic              aux_req = 1'b1;
  logic [ADDR_W-1:0] aux_addr = 12'h7FF;
  logic              aux_gnt;
  logic              aux_valid;
  logic [DATA_W-1:0] aux_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout = '0;
  logic              starve_clr = 1'b0;
  logic              aux_starved;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(16'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_active (vga_active),
    .vga_addr   (vga_addr),
    .vga_data   (vga_data),
    .aux_req    (aux_req),
    .aux_addr   (aux_addr),
    .aux_gnt    (aux_gnt),
    .aux_valid  (aux_valid),
    .aux_data   (aux_data),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .starve_clr (starve_clr),
    .aux_starved(aux_starved)
  );

  // ROM contents: two special words, everything else is {0xABC, addr}.
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    if (a == 12'h123) return 24'hA5A5A5;
    if (a == 12'h7FF) return 24'h00FF00;
    return {12'hABC, a};
  endfunction

  // Synchronous single-port ROM, one cycle read latency.
  always @(posedge clk) rom_dout <= rom_fn(rom_addr);

  typedef struct {
    logic              va;
    logic [ADDR_W-1:0] vaddr;
    logic              req;
    logic [ADDR_W-1:0] aaddr;
    logic              gnt;
    logic [ADDR_W-1:0] rom;
    logic              valid;
    logic [DATA_W-1:0] adata;
    logic [DATA_W-1:0] vdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic va, input logic [ADDR_W-1:0] vaddr,
                       input logic req, input logic [ADDR_W-1:0] aaddr);
    vga_active = va;
    vga_addr   = vaddr;
    aux_req    = req;
    aux_addr   = aaddr;
  endtask

  initial begin
    // Rows are consecutive cycles starting right after reset release.
    vecs[0]  = '{1'b1, 12'h123, 1'b0, 12'h000, 1'b0, 12'h123, 1'b0, 24'h000000, 24'hABC000};
    vecs[1]  = '{1'b1, 12'h124, 1'b1, 12'h7FF, 1'b0, 12'h124, 1'b0, 24'h000000, 24'hA5A5A5};
    vecs[2]  = '{1'b0, 12'h125, 1'b1, 12'h7FF, 1'b1, 12'h7FF, 1'b0, 24'h000000, 24'hABC124};
    vecs[3]  = '{1'b0, 12'h126, 1'b0, 12'h000, 1'b0, 12'h126, 1'b0, 24'h000000, 24'h00FF00};
    vecs[4]  = '{1'b0, 12'h127, 1'b0, 12'h000, 1'b0, 12'h127, 1'b1, 24'h00FF00, 24'hABC126};
    vecs[5]  = '{1'b0, 12'h128, 1'b1, 12'h200, 1'b1, 12'h200, 1'b0, 24'h00FF00, 24'hABC127};
    vecs[6]  = '{1'b1, 12'h010, 1'b0, 12'h000, 1'b0, 12'h010, 1'b0, 24'h00FF00, 24'hABC200};
    vecs[7]  = '{1'b1, 12'h011, 1'b1, 12'h300, 1'b0, 12'h011, 1'b1, 24'hABC200, 24'hABC010};
    vecs[8]  = '{1'b0, 12'h012, 1'b1, 12'h300, 1'b1, 12'h300, 1'b0, 24'hABC200, 24'hABC011};
    vecs[9]  = '{1'b0, 12'h013, 1'b1, 12'h300, 1'b0, 12'h013, 1'b0, 24'hABC200, 24'hABC300};
    vecs[10] = '{1'b0, 12'h014, 1'b1, 12'h300, 1'b1, 12'h300, 1'b1, 24'hABC300, 24'hABC013};
    vecs[11] = '{1'b0, 12'h015, 1'b0, 12'h000, 1'b0, 12'h015, 1'b0, 24'hABC300, 24'hABC300};
    vecs[12] = '{1'b0, 12'h016, 1'b0, 12'h000, 1'b0, 12'h016, 1'b1, 24'hABC300, 24'hABC015};
    vecs[13] = '{1'b0, 12'h016, 1'b0, 12'h000, 1'b0, 12'h016, 1'b0, 24'hABC300, 24'hABC016};

    // Reset state: request pending but no grant, port stays on VGA.
    @(negedge clk);
    chk("rst_gnt",     {31'd0, aux_gnt},     32'd0);
    chk("rst_rom",     {20'd0, rom_addr},    32'h055);
    chk("rst_valid",   {31'd0, aux_valid},   32'd0);
    chk("rst_adata",   {8'd0, aux_data},     32'd0);
    chk("rst_starved", {31'd0, aux_starved}, 32'd0);
    tick();
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    tick();
    rst = 1'b0;

    // Table-driven cycles.
    for (int i = 0; i < 14; i++) begin
      tick();
      drive(vecs[i].va, vecs[i].vaddr, vecs[i].req, vecs[i].aaddr);
      @(negedge clk);
      chk($sformatf("row%0d_gnt", i),   {31'd0, aux_gnt},   {31'd0, vecs[i].gnt});
      chk($sformatf("row%0d_rom", i),   {20'd0, rom_addr},  {20'd0, vecs[i].rom});
      chk($sformatf("row%0d_valid", i), {31'd0, aux_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("row%0d_adata", i), {8'd0, aux_data},   {8'd0, vecs[i].adata});
      chk($sformatf("row%0d_vdata", i), {8'd0, vga_data},   {8'd0, vecs[i].vdata});
      chk($sformatf("row%0d_starved", i), {31'd0, aux_starved}, 32'd0);
    end

    // Request held off by 50 cycles of continuous VGA activity.
    for (int c = 0; c < 50; c++) begin
      tick();
      drive(1'b1, 12'(c), 1'b1, 12'h456);
      @(negedge clk);
      chk($sformatf("block%0d_gnt", c),   {31'd0, aux_gnt},   32'd0);
      chk($sformatf("block%0d_valid", c), {31'd0, aux_valid}, 32'd0);
    end
    tick();
    drive(1'b0, 12'h040, 1'b1, 12'h456);
    @(negedge clk);
    chk("block_release_gnt", {31'd0, aux_gnt},  32'd1);
    chk("block_release_rom", {20'd0, rom_addr}, 32'h456);
    tick();
    drive(1'b0, 12'h041, 1'b0, 12'h000);
    tick();
    @(negedge clk);
    chk("block_valid", {31'd0, aux_valid}, 32'd1);
    chk("block_adata", {8'd0, aux_data},   32'hABC456);
    chk("block_starved", {31'd0, aux_starved}, {31'd0, WD_EN});
    tick();
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    @(negedge clk);
    chk("block_starved_clr", {31'd0, aux_starved}, 32'd0);

    // Starvation watchdog with limit 8: flag from cycle 9 of 20.
    for (int c = 1; c <= 20; c++) begin
      tick();
      drive(1'b1, 12'h060, 1'b1, 12'h111);
      @(negedge clk);
      chk($sformatf("wd_cyc%0d", c), {31'd0, aux_starved},
          {31'd0, (WD_EN && c >= 9)});
    end
    // Clear while still starving: set wins.
    tick();
    starve_clr = 1'b1;
    tick();
    @(negedge clk);
    chk("wd_set_wins", {31'd0, aux_starved}, {31'd0, WD_EN});
    // Drop the request so the counter clears, then the clear takes effect.
    drive(1'b0, 12'h061, 1'b0, 12'h000);
    tick();
    starve_clr = 1'b0;
    @(negedge clk);
    chk("wd_cleared", {31'd0, aux_starved}, 32'd0);

    // Reset during RD aborts the read.
    tick();
    drive(1'b0, 12'h070, 1'b1, 12'h5A5);
    @(negedge clk);
    chk("abort_gnt", {31'd0, aux_gnt}, 32'd1);
    tick();
    drive(1'b0, 12'h020, 1'b0, 12'h000);
    #1 rst = 1'b1;
    #1;
    chk("abort_valid_async", {31'd0, aux_valid}, 32'd0);
    chk("abort_adata_async", {8'd0, aux_data},   32'd0);
    chk("abort_rom",         {20'd0, rom_addr},  32'h020);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid_n2", {31'd0, aux_valid}, 32'd0);
    chk("abort_adata_n2", {8'd0, aux_data},   32'd0);
    tick();
    @(negedge clk);
    chk("abort_valid_n3", {31'd0, aux_valid}, 32'd0);
    // Back in IDLE: a fresh request is granted immediately.
    tick();
    drive(1'b0, 12'h021, 1'b1, 12'h0AA);
    @(negedge clk);
    chk("rereq_gnt", {31'd0, aux_gnt},  32'd1);
    chk("rereq_rom", {20'd0, rom_addr}, 32'h0AA);
    tick();
    drive(1'b0, 12'h022, 1'b0, 12'h000);
    tick();
    @(negedge clk);
    chk("rereq_valid", {31'd0, aux_valid}, 32'd1);
    chk("rereq_adata", {8'd0, aux_data},   32'hABC0AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
